// File: rtl/riscv_pkg.sv
// riscv_pkg: shared decode definitions for the RV32I pipeline.
//   - opcode constants for the supported instruction classes
//   - imm_type_t  : which immediate format an instruction carries
//   - alu_a_sel_t : ALU operand A source
//   - idex_ctrl_t : control bits carried in the ID/EX register
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_type_t;

  typedef enum logic [1:0] {
    ALU_A_RS1  = 2'd0,
    ALU_A_PC   = 2'd1,
    ALU_A_ZERO = 2'd2
  } alu_a_sel_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic       alu_src;
    logic       mem_to_reg;
    alu_a_sel_t alu_a_sel;
    logic       illegal;
  } idex_ctrl_t;

endpackage

// File: rtl/register_file.sv
// register_file: 32 x XLEN architectural registers, 2 combinational read
// ports, 1 write port.
//   clk, reset          : clock, synchronous active-high reset
//   rs1_addr, rs2_addr  : read indices
//   rs1_data, rs2_data  : read data (x0 reads 0)
//   wb_en, wb_rd, wb_data : write port, lands on the next rising edge
// A read of the register being written this cycle returns wb_data, so the
// decoder never sees a stale value while WB is still in flight.
module register_file #(
  parameter int XLEN      = 32,
  parameter bit REG_RESET = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data
);

  logic [XLEN-1:0] regs [32];

  always_ff @(posedge clk) begin
    if (reset && REG_RESET) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_en && (wb_rd != 5'd0)) begin
      regs[wb_rd] <= wb_data;
    end
  end

  always_comb begin
    rs1_data = '0;
    if (rs1_addr != 5'd0) begin
      if (wb_en && (wb_rd == rs1_addr)) rs1_data = wb_data;
      else                              rs1_data = regs[rs1_addr];
    end
  end

  always_comb begin
    rs2_data = '0;
    if (rs2_addr != 5'd0) begin
      if (wb_en && (wb_rd == rs2_addr)) rs2_data = wb_data;
      else                              rs2_data = regs[rs2_addr];
    end
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I instruction decode.
//   clk, reset              : clock, synchronous active-high reset
//   instruction_D, PC_D     : IF/ID contents
//   flush                   : ID holds a wrong-path instruction
//   wb_en, wb_rd, wb_data   : register-file write from WB
//   stall                   : load-use hazard, freeze PC and IF/ID
//   *_E                     : registered ID/EX bundle (data, indices, control)
module decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit REG_RESET = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instruction_D,
  input  logic [XLEN-1:0] PC_D,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            stall,
  output logic [XLEN-1:0] PC_E,
  output logic [XLEN-1:0] rs1_data_E,
  output logic [XLEN-1:0] rs2_data_E,
  output logic [XLEN-1:0] imm_E,
  output logic [4:0]      rs1_E,
  output logic [4:0]      rs2_E,
  output logic [4:0]      rd_E,
  output logic [2:0]      funct3_E,
  output logic            funct7b5_E,
  output logic            reg_write_E,
  output logic            mem_read_E,
  output logic            mem_write_E,
  output logic            branch_E,
  output logic            jal_E,
  output logic            jalr_E,
  output logic            alu_src_E,
  output logic            mem_to_reg_E,
  output logic [1:0]      alu_a_sel_E,
  output logic            illegal_E
);

  logic [6:0] opcode;
  logic [4:0] rd_d, rs1_d, rs2_d;
  logic [2:0] funct3_d;

  assign opcode   = instruction_D[6:0];
  assign rd_d     = instruction_D[11:7];
  assign funct3_d = instruction_D[14:12];
  assign rs1_d    = instruction_D[19:15];
  assign rs2_d    = instruction_D[24:20];

  idex_ctrl_t ctrl_d;
  imm_type_t  imm_type;
  logic       rs1_used, rs2_used;

  always_comb begin
    ctrl_d   = '0;
    imm_type = IMM_NONE;
    rs1_used = 1'b1;
    rs2_used = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl_d.reg_write = 1'b1;
        rs2_used         = 1'b1;
      end
      OP_IMM: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        imm_type         = IMM_I;
      end
      OP_LOAD: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.mem_read   = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
        ctrl_d.alu_src    = 1'b1;
        imm_type          = IMM_I;
      end
      OP_STORE: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        imm_type         = IMM_S;
        rs2_used         = 1'b1;
      end
      OP_BRANCH: begin
        ctrl_d.branch = 1'b1;
        imm_type      = IMM_B;
        rs2_used      = 1'b1;
      end
      OP_JAL: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.jal       = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.alu_a_sel = ALU_A_PC;
        imm_type         = IMM_J;
        rs1_used         = 1'b0;
      end
      OP_JALR: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.jalr      = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        imm_type         = IMM_I;
      end
      OP_LUI: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.alu_a_sel = ALU_A_ZERO;
        imm_type         = IMM_U;
        rs1_used         = 1'b0;
      end
      OP_AUIPC: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.alu_a_sel = ALU_A_PC;
        imm_type         = IMM_U;
        rs1_used         = 1'b0;
      end
      default: ctrl_d.illegal = 1'b1;
    endcase
    // Writes to x0 are architecturally discarded; drop them here so EX/WB
    // forwarding never treats x0 as a live destination.
    if (rd_d == 5'd0) ctrl_d.reg_write = 1'b0;
  end

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (imm_type)
      IMM_I: imm32 = {{20{instruction_D[31]}}, instruction_D[31:20]};
      IMM_S: imm32 = {{20{instruction_D[31]}}, instruction_D[31:25],
                      instruction_D[11:7]};
      IMM_B: imm32 = {{19{instruction_D[31]}}, instruction_D[31], instruction_D[7],
                      instruction_D[30:25], instruction_D[11:8], 1'b0};
      IMM_U: imm32 = {instruction_D[31:12], 12'b0};
      IMM_J: imm32 = {{11{instruction_D[31]}}, instruction_D[31], instruction_D[19:12],
                      instruction_D[20], instruction_D[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  logic [XLEN-1:0] rs1_data_d, rs2_data_d;

  register_file #(
    .XLEN      (XLEN),
    .REG_RESET (REG_RESET)
  ) u_register_file (
    .clk      (clk),
    .reset    (reset),
    .rs1_addr (rs1_d),
    .rs2_addr (rs2_d),
    .rs1_data (rs1_data_d),
    .rs2_data (rs2_data_d),
    .wb_en    (wb_en),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data)
  );

  idex_ctrl_t ctrl_q;

  // flush masks the hazard: a wrong-path instruction is discarded anyway,
  // so holding IF/ID for it would only waste the redirect cycle.
  assign stall = ctrl_q.mem_read && (rd_E != 5'd0) &&
                 (((rd_E == rs1_d) && rs1_used) || ((rd_E == rs2_d) && rs2_used)) &&
                 !flush;

  always_ff @(posedge clk) begin
    if (reset || flush || stall) begin
      ctrl_q     <= '0;
      PC_E       <= '0;
      rs1_data_E <= '0;
      rs2_data_E <= '0;
      imm_E      <= '0;
      rs1_E      <= '0;
      rs2_E      <= '0;
      rd_E       <= '0;
      funct3_E   <= '0;
      funct7b5_E <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      PC_E       <= PC_D;
      rs1_data_E <= rs1_data_d;
      rs2_data_E <= rs2_data_d;
      imm_E      <= XLEN'($signed(imm32));
      rs1_E      <= rs1_d;
      rs2_E      <= rs2_d;
      rd_E       <= rd_d;
      funct3_E   <= funct3_d;
      funct7b5_E <= instruction_D[30];
    end
  end

  assign reg_write_E  = ctrl_q.reg_write;
  assign mem_read_E   = ctrl_q.mem_read;
  assign mem_write_E  = ctrl_q.mem_write;
  assign branch_E     = ctrl_q.branch;
  assign jal_E        = ctrl_q.jal;
  assign jalr_E       = ctrl_q.jalr;
  assign alu_src_E    = ctrl_q.alu_src;
  assign mem_to_reg_E = ctrl_q.mem_to_reg;
  assign alu_a_sel_E  = ctrl_q.alu_a_sel;
  assign illegal_E    = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction_D, PC_D, wb_data;
  logic        flush, wb_en;
  logic [4:0]  wb_rd;
  logic        stall;
  logic [31:0] PC_E, rs1_data_E, rs2_data_E, imm_E;
  logic [4:0]  rs1_E, rs2_E, rd_E;
  logic [2:0]  funct3_E;
  logic        funct7b5_E;
  logic        reg_write_E, mem_read_E, mem_write_E, branch_E, jal_E, jalr_E;
  logic        alu_src_E, mem_to_reg_E, illegal_E;
  logic [1:0]  alu_a_sel_E;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .REG_RESET(1'b1)) dut (
    .clk(clk), .reset(reset), .instruction_D(instruction_D), .PC_D(PC_D),
    .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall(stall), .PC_E(PC_E), .rs1_data_E(rs1_data_E), .rs2_data_E(rs2_data_E),
    .imm_E(imm_E), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
    .funct3_E(funct3_E), .funct7b5_E(funct7b5_E),
    .reg_write_E(reg_write_E), .mem_read_E(mem_read_E), .mem_write_E(mem_write_E),
    .branch_E(branch_E), .jal_E(jal_E), .jalr_E(jalr_E), .alu_src_E(alu_src_E),
    .mem_to_reg_E(mem_to_reg_E), .alu_a_sel_E(alu_a_sel_E), .illegal_E(illegal_E)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference state: architectural registers and the expected ID/EX bundle.
  // ctrl = {reg_write, mem_read, mem_write, branch, jal, jalr, alu_src,
  //         mem_to_reg, alu_a_sel[1:0], illegal}
  // idx  = {rs1, rs2, rd, funct3, funct7b5}
  logic [31:0] mreg [32];
  logic [31:0] e_pc, e_rs1d, e_rs2d, e_imm;
  logic [18:0] e_idx;
  logic [10:0] e_ctrl;
  logic        seen_stall;

  task automatic model_decode(input logic [31:0] i, output logic [10:0] c,
                              output logic [31:0] imm, output bit u1, output bit u2);
    bit rw, mr, mw, br, jl, jr, as, m2r, ill;
    logic [1:0] asel;
    rw = 0; mr = 0; mw = 0; br = 0; jl = 0; jr = 0; as = 0; m2r = 0; ill = 0;
    asel = 2'd0; imm = 32'd0; u1 = 1; u2 = 0;
    case (i[6:0])
      7'b0110011: begin rw = 1; u2 = 1; end
      7'b0010011: begin rw = 1; as = 1; imm = 32'($signed(i[31:20])); end
      7'b0000011: begin rw = 1; mr = 1; m2r = 1; as = 1; imm = 32'($signed(i[31:20])); end
      7'b0100011: begin mw = 1; as = 1; u2 = 1; imm = 32'($signed({i[31:25], i[11:7]})); end
      7'b1100011: begin br = 1; u2 = 1;
                        imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})); end
      7'b1101111: begin rw = 1; jl = 1; as = 1; asel = 2'd1; u1 = 0;
                        imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})); end
      7'b1100111: begin rw = 1; jr = 1; as = 1; imm = 32'($signed(i[31:20])); end
      7'b0110111: begin rw = 1; as = 1; asel = 2'd2; u1 = 0; imm = {i[31:12], 12'h000}; end
      7'b0010111: begin rw = 1; as = 1; asel = 2'd1; u1 = 0; imm = {i[31:12], 12'h000}; end
      default:    ill = 1;
    endcase
    if (i[11:7] == 5'd0) rw = 0;
    c = {rw, mr, mw, br, jl, jr, as, m2r, asel, ill};
  endtask

  function automatic logic [31:0] mread(input logic [4:0] a, input logic we,
                                        input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (we && wa == a) return wd;
    return mreg[a];
  endfunction

  // One cycle: drive at the falling edge, check stall mid-cycle, check the
  // ID/EX bundle just after the rising edge.
  task automatic step(input logic rst, input logic [31:0] ins, input logic [31:0] pc,
                      input logic fl, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd);
    logic [10:0] c;
    logic [31:0] imm;
    bit u1, u2, hz;
    logic [4:0] ers, rs1, rs2;
    reset = rst; instruction_D = ins; PC_D = pc; flush = fl;
    wb_en = we; wb_rd = wa; wb_data = wd;
    #1;
    model_decode(ins, c, imm, u1, u2);
    rs1 = ins[19:15]; rs2 = ins[24:20]; ers = e_idx[8:4];
    hz = e_ctrl[9] && ers != 0 && ((ers == rs1 && u1) || (ers == rs2 && u2)) && !fl;
    seen_stall = stall;
    check("stall", {31'd0, stall}, {31'd0, hz});
    if (rst || fl || hz) begin
      e_pc = 0; e_rs1d = 0; e_rs2d = 0; e_imm = 0; e_idx = 0; e_ctrl = 0;
    end else begin
      e_pc = pc; e_rs1d = mread(rs1, we, wa, wd); e_rs2d = mread(rs2, we, wa, wd);
      e_imm = imm; e_ctrl = c;
      e_idx = {rs1, rs2, ins[11:7], ins[14:12], ins[30]};
    end
    if (rst) begin
      for (int k = 0; k < 32; k++) mreg[k] = 32'd0;
    end else if (we && wa != 0) begin
      mreg[wa] = wd;
    end
    @(posedge clk); #1;
    check("pc_e", PC_E, e_pc);
    check("rs1_data_e", rs1_data_E, e_rs1d);
    check("rs2_data_e", rs2_data_E, e_rs2d);
    check("imm_e", imm_E, e_imm);
    check("idx_e", {13'd0, rs1_E, rs2_E, rd_E, funct3_E, funct7b5_E}, {13'd0, e_idx});
    check("ctrl_e", {21'd0, reg_write_E, mem_read_E, mem_write_E, branch_E, jal_E, jalr_E,
                     alu_src_E, mem_to_reg_E, alu_a_sel_E, illegal_E}, {21'd0, e_ctrl});
    @(negedge clk);
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs2, rs1, rd);
    return {7'd0, rs2, rs1, 3'd0, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  logic [6:0] ops [11];
  logic [31:0] ins_r, pc_r;
  logic prev_stall;
  logic [12:0] bimm;
  logic [20:0] jimm;

  initial begin
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'h7F};
    for (int k = 0; k < 32; k++) mreg[k] = 32'hX;
    e_pc = 0; e_rs1d = 0; e_rs2d = 0; e_imm = 0; e_idx = 0; e_ctrl = 0;
    reset = 1; instruction_D = 0; PC_D = 0; flush = 0; wb_en = 0; wb_rd = 0; wb_data = 0;
    @(negedge clk);
    // e_ctrl starts at 0 so the reset-cycle stall expectation is 0.
    step(1, enc_r(0, 0, 0), 32'h0, 0, 0, 0, 0);
    step(1, enc_r(0, 0, 0), 32'h0, 0, 0, 0, 0);
    check("rst_ctrl", {21'd0, reg_write_E, mem_read_E, mem_write_E, branch_E, jal_E, jalr_E,
                       alu_src_E, mem_to_reg_E, alu_a_sel_E, illegal_E}, 32'd0);

    // Bypass: write x5 in the same cycle as add x6,x5,x0 decodes.
    step(0, enc_r(5'd0, 5'd5, 5'd6), 32'h100, 0, 1, 5'd5, 32'hDEADBEEF);
    check("tp_bypass_rs1", rs1_data_E, 32'hDEADBEEF);
    check("tp_bypass_rw", {31'd0, reg_write_E}, 32'd1);
    check("tp_bypass_rd", {27'd0, rd_E}, 32'd6);

    // Write to x0 ignored; addi x1,x0,-1.
    step(0, enc_i(12'd0, 5'd0, 3'd0, 5'd0, 7'b0010011), 32'h104, 0, 1, 5'd0, 32'h1234);
    step(0, enc_i(12'hFFF, 5'd0, 3'd0, 5'd1, 7'b0010011), 32'h108, 0, 0, 5'd0, 32'd0);
    check("tp_x0_rs1", rs1_data_E, 32'd0);
    check("tp_x0_imm", imm_E, 32'hFFFFFFFF);
    check("tp_x0_alusrc", {31'd0, alu_src_E}, 32'd1);

    // Load-use: lw x3,0(x2); add x4,x3,x1.
    step(0, enc_i(12'd0, 5'd2, 3'b010, 5'd3, 7'b0000011), 32'h10C, 0, 0, 0, 0);
    step(0, enc_r(5'd1, 5'd3, 5'd4), 32'h110, 0, 0, 0, 0);
    check("tp_lu_stall", {31'd0, seen_stall}, 32'd1);
    check("tp_lu_bubble", {31'd0, mem_read_E | reg_write_E}, 32'd0);
    step(0, enc_r(5'd1, 5'd3, 5'd4), 32'h110, 0, 0, 0, 0);
    check("tp_lu_nostall", {31'd0, seen_stall}, 32'd0);
    check("tp_lu_rs1", {27'd0, rs1_E}, 32'd3);

    // Load then lui x3 (rs1 unused): no stall.
    step(0, enc_i(12'd0, 5'd2, 3'b010, 5'd3, 7'b0000011), 32'h114, 0, 0, 0, 0);
    step(0, {20'h12345, 5'd3, 7'b0110111}, 32'h118, 0, 0, 0, 0);
    check("tp_lui_stall", {31'd0, seen_stall}, 32'd0);
    check("tp_lui_imm", imm_E, 32'h12345000);
    check("tp_lui_asel", {30'd0, alu_a_sel_E}, 32'd2);

    // Load-use pair under flush.
    step(0, enc_i(12'd0, 5'd2, 3'b010, 5'd3, 7'b0000011), 32'h11C, 0, 0, 0, 0);
    step(0, enc_r(5'd1, 5'd3, 5'd4), 32'h120, 1, 0, 0, 0);
    check("tp_flush_stall", {31'd0, seen_stall}, 32'd0);
    check("tp_flush_bubble", {31'd0, reg_write_E | illegal_E}, 32'd0);

    // beq x1,x2,-8
    bimm = 13'h1FF8;
    step(0, {bimm[12], bimm[10:5], 5'd2, 5'd1, 3'd0, bimm[4:1], bimm[11], 7'b1100011},
         32'h124, 0, 0, 0, 0);
    check("tp_beq_imm", imm_E, 32'hFFFFFFF8);
    check("tp_beq_br", {31'd0, branch_E}, 32'd1);
    // jal x1,+2048
    jimm = 21'd2048;
    step(0, {jimm[20], jimm[10:1], jimm[11], jimm[19:12], 5'd1, 7'b1101111},
         32'h128, 0, 0, 0, 0);
    check("tp_jal_imm", imm_E, 32'h00000800);
    check("tp_jal_asel", {30'd0, alu_a_sel_E}, 32'd1);
    // Illegal opcode 0x7F
    step(0, {25'h1ABCDE, 7'h7F}, 32'h12C, 0, 0, 0, 0);
    check("tp_illegal", {21'd0, reg_write_E, mem_read_E, mem_write_E, branch_E, jal_E, jalr_E,
                         alu_src_E, mem_to_reg_E, alu_a_sel_E, illegal_E}, 32'd1);

    // Randomized traffic; IF/ID is held while stalled, as the pipeline would.
    prev_stall = 0; ins_r = 0; pc_r = 32'h200;
    for (int n = 0; n < 400; n++) begin
      logic rst, fl, we;
      logic [4:0] wa;
      rst = ($urandom_range(0, 63) == 0);
      fl  = ($urandom_range(0, 7) == 0);
      we  = $urandom_range(0, 1);
      wa  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      if (!prev_stall || rst) begin
        ins_r = $urandom;
        ins_r[6:0]   = ops[$urandom_range(0, 10)];
        ins_r[11:7]  = 5'($urandom_range(0, 7));
        ins_r[19:15] = 5'($urandom_range(0, 7));
        ins_r[24:20] = 5'($urandom_range(0, 7));
        pc_r = pc_r + 4;
      end
      step(rst, ins_r, pc_r, fl, we, wa, $urandom);
      prev_stall = seen_stall;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
